// File: rtl/hazard_fwd_ctrl.sv
// Hazard/forwarding controller for the 5-stage core: load-use and
// HI/LO interlocks, branch flush, and registered ALU operand selects.
module hazard_fwd_ctrl #(
  parameter int RAW    = 5,
  parameter int MD_LAT = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [RAW-1:0] id_rs,
  input  logic [RAW-1:0] id_rt,
  input  logic           id_use_rs,
  input  logic           id_use_rt,
  input  logic           id_muldiv,
  input  logic           id_hilo_use,
  input  logic [RAW-1:0] ex_rd,
  input  logic           ex_regwrite,
  input  logic           ex_memread,
  input  logic [RAW-1:0] mem_rd,
  input  logic           mem_regwrite,
  input  logic           ex_br_taken,
  output logic [1:0]     fwd_a_sel,
  output logic [1:0]     fwd_b_sel,
  output logic           pc_stall,
  output logic           ifid_stall,
  output logic           idex_bubble,
  output logic           ifid_flush,
  output logic           md_busy
);

  localparam int CW = (MD_LAT > 1) ? $clog2(MD_LAT) : 1;

  typedef enum logic {RUN, MD_BUSY} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic          md_busy_q, md_busy_d;
  logic [1:0]    fwd_a_q, fwd_a_d;
  logic [1:0]    fwd_b_q, fwd_b_d;
  logic          lu, mds, stall, bubble, issue;

  // EX match wins over MEM: it is the younger producer.
  function automatic logic [1:0] fwd_sel(
    input logic [RAW-1:0] src,
    input logic [RAW-1:0] e_rd,
    input logic           e_wr,
    input logic [RAW-1:0] m_rd,
    input logic           m_wr
  );
    logic [1:0] s;
    s = 2'b00;
    if (e_wr && e_rd != '0 && e_rd == src)
      s = 2'b01;
    else if (m_wr && m_rd != '0 && m_rd == src)
      s = 2'b10;
    return s;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= RUN;
      count_q   <= '0;
      md_busy_q <= 1'b0;
      fwd_a_q   <= 2'b00;
      fwd_b_q   <= 2'b00;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      md_busy_q <= md_busy_d;
      fwd_a_q   <= fwd_a_d;
      fwd_b_q   <= fwd_b_d;
    end
  end

  always_comb begin
    lu = ex_memread && ex_rd != '0 &&
         ((id_use_rs && id_rs == ex_rd) ||
          (id_use_rt && id_rt == ex_rd));
    mds    = md_busy_q && (id_muldiv || id_hilo_use);
    stall  = (lu || mds) && !ex_br_taken;
    bubble = stall || ex_br_taken;
    issue  = id_muldiv && !bubble;
  end

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    md_busy_d = md_busy_q;
    unique case (state_q)
      RUN: begin
        if (issue) begin
          state_d   = MD_BUSY;
          count_d   = CW'(MD_LAT - 1);
          md_busy_d = 1'b1;
        end
      end
      MD_BUSY: begin
        if (count_q == '0) begin
          state_d   = RUN;
          md_busy_d = 1'b0;
        end else begin
          count_d = count_q - CW'(1);
        end
      end
    endcase
  end

  always_comb begin
    fwd_a_d = 2'b00;
    fwd_b_d = 2'b00;
    if (!bubble) begin
      fwd_a_d = fwd_sel(id_rs, ex_rd, ex_regwrite,
                        mem_rd, mem_regwrite);
      fwd_b_d = fwd_sel(id_rt, ex_rd, ex_regwrite,
                        mem_rd, mem_regwrite);
    end
    pc_stall    = stall && !rst;
    ifid_stall  = stall && !rst;
    idex_bubble = bubble && !rst;
    ifid_flush  = ex_br_taken && !rst;
    fwd_a_sel   = fwd_a_q;
    fwd_b_sel   = fwd_b_q;
    md_busy     = md_busy_q;
  end

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// Bench for hazard_fwd_ctrl: directed vector table, hand sequences
// for mul/div and async reset, then random stimulus vs a model.
module tb_hazard_fwd_ctrl;

  localparam int RAW    = 5;
  localparam int MD_LAT = 4;

  typedef struct packed {
    logic [4:0] rs;
    logic [4:0] rt;
    logic       use_rs;
    logic       use_rt;
    logic       muldiv;
    logic       hilo;
    logic [4:0] ex_rd;
    logic       ex_rw;
    logic       ex_mr;
    logic [4:0] mem_rd;
    logic       mem_rw;
    logic       br;
  } in_t;

  typedef struct packed {
    in_t        i;
    logic       st;
    logic       bub;
    logic       fl;
    logic [1:0] sa;
    logic [1:0] sb;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] id_rs, id_rt, ex_rd, mem_rd;
  logic       id_use_rs, id_use_rt, id_muldiv, id_hilo_use;
  logic       ex_regwrite, ex_memread, mem_regwrite, ex_br_taken;
  logic [1:0] fwd_a_sel, fwd_b_sel;
  logic       pc_stall, ifid_stall, idex_bubble, ifid_flush, md_busy;

  int errors = 0;
  int checks = 0;

  int         m_left = 0;
  logic [1:0] m_sa = 2'b00;
  logic [1:0] m_sb = 2'b00;

  hazard_fwd_ctrl #(.RAW(RAW), .MD_LAT(MD_LAT)) dut (
    .clk(clk), .rst(rst),
    .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .id_muldiv(id_muldiv), .id_hilo_use(id_hilo_use),
    .ex_rd(ex_rd), .ex_regwrite(ex_regwrite),
    .ex_memread(ex_memread),
    .mem_rd(mem_rd), .mem_regwrite(mem_regwrite),
    .ex_br_taken(ex_br_taken),
    .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
    .pc_stall(pc_stall), .ifid_stall(ifid_stall),
    .idex_bubble(idex_bubble), .ifid_flush(ifid_flush),
    .md_busy(md_busy)
  );

  always #5 clk = ~clk;

  function automatic in_t mk(
    int rs, int rt, bit urs, bit urt, bit md, bit hl,
    int erd, bit erw, bit emr, int mrd, bit mrw, bit br
  );
    in_t r;
    r.rs = 5'(rs);      r.rt = 5'(rt);
    r.use_rs = urs;     r.use_rt = urt;
    r.muldiv = md;      r.hilo = hl;
    r.ex_rd = 5'(erd);  r.ex_rw = erw;
    r.ex_mr = emr;      r.mem_rd = 5'(mrd);
    r.mem_rw = mrw;     r.br = br;
    return r;
  endfunction

  task automatic chk(input string tag, input string nm,
                     input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s %s: got %0d expected %0d",
               tag, nm, act, exp);
    end
  endtask

  task automatic apply(input in_t i);
    id_rs = i.rs;           id_rt = i.rt;
    id_use_rs = i.use_rs;   id_use_rt = i.use_rt;
    id_muldiv = i.muldiv;   id_hilo_use = i.hilo;
    ex_rd = i.ex_rd;        ex_regwrite = i.ex_rw;
    ex_memread = i.ex_mr;   mem_rd = i.mem_rd;
    mem_regwrite = i.mem_rw; ex_br_taken = i.br;
  endtask

  // Reference forward choice: youngest writer of a non-zero register.
  function automatic logic [1:0] ref_sel(input logic [4:0] x,
                                         input in_t i);
    if (x == 0) return 2'b00;
    if (i.ex_rw && i.ex_rd == x) return 2'b01;
    if (i.mem_rw && i.mem_rd == x) return 2'b10;
    return 2'b00;
  endfunction

  task automatic step(input in_t i, input string tag);
    bit lu, busy, st, bub;
    @(negedge clk);
    apply(i);
    #1;
    busy = (m_left > 0);
    lu = i.ex_mr && i.ex_rd != 0 &&
         ((i.use_rs && i.rs == i.ex_rd) ||
          (i.use_rt && i.rt == i.ex_rd));
    st  = (lu || (busy && (i.muldiv || i.hilo))) && !i.br;
    bub = st || i.br;
    chk(tag, "pc_stall", pc_stall, st);
    chk(tag, "ifid_stall", ifid_stall, st);
    chk(tag, "idex_bubble", idex_bubble, bub);
    chk(tag, "ifid_flush", ifid_flush, i.br);
    chk(tag, "md_busy", md_busy, busy);
    chk(tag, "fwd_a_sel", fwd_a_sel, m_sa);
    chk(tag, "fwd_b_sel", fwd_b_sel, m_sb);
    @(posedge clk);
    m_sa = bub ? 2'b00 : ref_sel(i.rs, i);
    m_sb = bub ? 2'b00 : ref_sel(i.rt, i);
    if (m_left > 0) m_left--;
    else if (i.muldiv && !bub) m_left = MD_LAT;
  endtask

  task automatic check_all_zero(input string tag);
    chk(tag, "pc_stall", pc_stall, 0);
    chk(tag, "ifid_stall", ifid_stall, 0);
    chk(tag, "idex_bubble", idex_bubble, 0);
    chk(tag, "ifid_flush", ifid_flush, 0);
    chk(tag, "md_busy", md_busy, 0);
    chk(tag, "fwd_a_sel", fwd_a_sel, 0);
    chk(tag, "fwd_b_sel", fwd_b_sel, 0);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    rst = 1'b1;
    apply(mk(5, 5, 1, 1, 1, 1, 5, 1, 1, 5, 1, 1));
    #1;
    check_all_zero(tag);
    @(negedge clk);
    rst = 1'b0;
    m_left = 0;
    m_sa = 2'b00;
    m_sb = 2'b00;
  endtask

  vec_t tbl[11];
  in_t  nop;
  int   hi_cnt;

  initial begin
    nop = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    //            rs rt urs urt md hl erd erw emr mrd mrw br
    tbl[0]  = {mk(3, 4, 1, 1, 0, 0, 3, 1, 0, 0, 0, 0),
               1'b0, 1'b0, 1'b0, 2'b01, 2'b00};
    tbl[1]  = {mk(1, 5, 1, 1, 0, 0, 5, 1, 1, 0, 0, 0),
               1'b1, 1'b1, 1'b0, 2'b00, 2'b00};
    tbl[2]  = {mk(1, 5, 1, 1, 0, 0, 0, 0, 0, 5, 1, 0),
               1'b0, 1'b0, 1'b0, 2'b00, 2'b10};
    tbl[3]  = {mk(0, 0, 1, 1, 0, 0, 0, 1, 0, 0, 1, 0),
               1'b0, 1'b0, 1'b0, 2'b00, 2'b00};
    tbl[4]  = {mk(7, 7, 1, 1, 0, 0, 7, 1, 0, 7, 1, 0),
               1'b0, 1'b0, 1'b0, 2'b01, 2'b01};
    tbl[5]  = {mk(5, 2, 1, 1, 0, 0, 5, 1, 1, 2, 1, 1),
               1'b0, 1'b1, 1'b1, 2'b00, 2'b00};
    tbl[6]  = {mk(5, 6, 0, 1, 0, 0, 5, 1, 1, 0, 0, 0),
               1'b0, 1'b0, 1'b0, 2'b01, 2'b00};
    tbl[7]  = {mk(9, 10, 1, 1, 0, 0, 10, 1, 0, 9, 1, 0),
               1'b0, 1'b0, 1'b0, 2'b10, 2'b01};
    tbl[8]  = {mk(0, 0, 1, 1, 0, 0, 0, 0, 1, 0, 0, 0),
               1'b0, 1'b0, 1'b0, 2'b00, 2'b00};
    tbl[9]  = {mk(12, 3, 1, 1, 0, 0, 0, 0, 0, 12, 0, 0),
               1'b0, 1'b0, 1'b0, 2'b00, 2'b00};
    tbl[10] = {mk(8, 8, 1, 1, 0, 1, 8, 0, 0, 0, 0, 0),
               1'b0, 1'b0, 1'b0, 2'b00, 2'b00};

    apply(mk(5, 5, 1, 1, 1, 1, 5, 1, 1, 5, 1, 0));
    #2;
    check_all_zero("reset_init");
    @(negedge clk);
    rst = 1'b0;

    for (int k = 0; k < 11; k++) begin
      string tg;
      tg = $sformatf("tbl%0d", k);
      @(negedge clk);
      apply(tbl[k].i);
      #1;
      chk(tg, "pc_stall", pc_stall, tbl[k].st);
      chk(tg, "ifid_stall", ifid_stall, tbl[k].st);
      chk(tg, "idex_bubble", idex_bubble, tbl[k].bub);
      chk(tg, "ifid_flush", ifid_flush, tbl[k].fl);
      @(posedge clk);
      #1;
      chk(tg, "fwd_a_sel", fwd_a_sel, tbl[k].sa);
      chk(tg, "fwd_b_sel", fwd_b_sel, tbl[k].sb);
    end

    do_reset("reset_after_tbl");

    // mult then mfhi held in ID: busy exactly MD_LAT cycles
    step(mk(1, 2, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0), "mult");
    hi_cnt = 0;
    for (int k = 0; k < MD_LAT + 2; k++) begin
      step(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0), "mfhi");
      if (md_busy) hi_cnt++;
    end
    chk("mult", "busy_cycles", hi_cnt, MD_LAT);

    // back-to-back muldiv stalls then issues
    step(mk(1, 2, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0), "md1");
    for (int k = 0; k < MD_LAT + 3; k++)
      step(mk(3, 4, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0), "md2");
    for (int k = 0; k < MD_LAT + 1; k++) step(nop, "drain");

    // taken branch blocks a new issue
    step(mk(1, 2, 1, 1, 1, 0, 0, 0, 0, 0, 0, 1), "md_br");
    step(nop, "md_br_after");
    chk("md_br", "md_busy_after", md_busy, 0);

    // async reset mid MD_BUSY with nonzero selects pending
    step(mk(1, 2, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0), "md_rst");
    step(mk(6, 7, 1, 1, 0, 0, 6, 1, 0, 7, 1, 0), "md_rst_fwd");
    chk("md_rst", "busy_before", md_busy, 1);
    #3;
    rst = 1'b1;
    apply(mk(5, 5, 1, 1, 1, 1, 5, 1, 1, 5, 1, 0));
    #1;
    check_all_zero("async_rst");
    @(negedge clk);
    rst = 1'b0;
    m_left = 0;
    m_sa = 2'b00;
    m_sb = 2'b00;

    for (int n = 0; n < 400; n++) begin
      in_t r;
      r.rs     = 5'($urandom_range(0, 3));
      r.rt     = 5'($urandom_range(0, 3));
      r.use_rs = 1'($urandom_range(0, 1));
      r.use_rt = 1'($urandom_range(0, 1));
      r.muldiv = ($urandom_range(0, 5) == 0);
      r.hilo   = ($urandom_range(0, 3) == 0);
      r.ex_rd  = 5'($urandom_range(0, 3));
      r.ex_rw  = 1'($urandom_range(0, 1));
      r.ex_mr  = ($urandom_range(0, 2) == 0);
      r.mem_rd = 5'($urandom_range(0, 3));
      r.mem_rw = 1'($urandom_range(0, 1));
      r.br     = ($urandom_range(0, 7) == 0);
      step(r, "rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
